// File: rtl/audio_pkg.sv
// Shared types and constants for the PWM audio output path.
package audio_pkg;

  localparam int SAMPLE_W = 6;
  localparam logic [SAMPLE_W-1:0] MID_LEVEL = 6'd32;
  localparam logic [SAMPLE_W-1:0] LEVEL_ONE = 6'd1;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } pwm_state_t;

  // One-LSB move toward tgt; returns cur unchanged when already there.
  function automatic logic [SAMPLE_W-1:0] step_toward(
    input logic [SAMPLE_W-1:0] cur,
    input logic [SAMPLE_W-1:0] tgt
  );
    if (cur < tgt) begin
      return cur + LEVEL_ONE;
    end else if (cur > tgt) begin
      return cur - LEVEL_ONE;
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/pwm_dac.sv
// 64-clock PWM modulator; duty is reloaded only at period wrap so a level
// change never disturbs the period in progress.
module pwm_dac
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic [SAMPLE_W-1:0] level_i,
  output logic                pwm_o
);

  logic [SAMPLE_W-1:0] pwm_cnt_q;
  logic [SAMPLE_W-1:0] duty_q;
  logic                pwm_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + LEVEL_ONE;
      if (&pwm_cnt_q) begin
        duty_q <= level_i;
      end
      pwm_q <= (pwm_cnt_q < duty_q);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/audio_pwm_out.sv
// Audio output stage: sample-rate timebase, click-free enable/disable ramp
// state machine and PWM pin driver.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int unsigned          SAMPLE_DIV = 1134,
  parameter logic [SAMPLE_W-1:0]  MID        = MID_LEVEL
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [15:0]         voices_active,
  output logic                sample_strobe,
  output logic [SAMPLE_W-1:0] level,
  output logic                ramping,
  output logic                pwm_out,
  output pwm_state_t          state_dbg
);

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  logic [15:0]         div_cnt_q;
  logic                strobe_q;
  pwm_state_t          state_q, state_d;
  logic [SAMPLE_W-1:0] level_q, level_d;
  logic                ramping_q;

  // sample_strobe is a bare one-clock pulse with no back-pressure: upstream
  // must present a stable sample_in/voices_active while it is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      div_cnt_q <= (div_cnt_q == DIV_LAST) ? 16'd0 : div_cnt_q + 16'd1;
      strobe_q  <= (div_cnt_q == DIV_LAST);
    end
  end

  // Level steps follow the current state's rule; enable changes the state on
  // the same edge, so a coinciding strobe still uses the old rule.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      OFF: begin
        level_d = '0;
        if (enable) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (strobe_q) begin
          level_d = step_toward(level_q, MID);
          if (step_toward(level_q, MID) == MID) state_d = RUN;
        end
        if (!enable) state_d = RAMP_DOWN;
      end
      RUN: begin
        // The mixer divides by the voice count, so its output is meaningless
        // with no voice playing; hold silence instead.
        if (strobe_q) level_d = (|voices_active) ? sample_in : MID;
        if (!enable) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (strobe_q) begin
          level_d = (level_q == '0) ? '0 : level_q - LEVEL_ONE;
          if (level_q <= LEVEL_ONE) state_d = OFF;
        end
        if (enable) state_d = RAMP_UP;
      end
      default: begin
        state_d = OFF;
        level_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= OFF;
      level_q   <= '0;
      ramping_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      ramping_q <= (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
    end
  end

  pwm_dac u_dac (
    .clk     (clk),
    .resetn  (resetn),
    .level_i (level_q),
    .pwm_o   (pwm_out)
  );

  assign sample_strobe = strobe_q;
  assign level         = level_q;
  assign ramping       = ramping_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out with a fast 64-clock sample timebase.
module tb_audio_pwm_out;
  import audio_pkg::*;

  localparam int DIV = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        enable = 1'b0;
  logic [5:0]  sample_in = '0;
  logic [15:0] voices_active = '0;
  logic        sample_strobe;
  logic [5:0]  level;
  logic        ramping;
  logic        pwm_out;
  pwm_state_t  state_dbg;

  // Each entry is {ramping, level} expected one clock after a strobe.
  logic [6:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  bit strobe_seen = 1'b0;

  audio_pwm_out #(.SAMPLE_DIV(DIV), .MID(6'd32)) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .sample_in     (sample_in),
    .voices_active (voices_active),
    .sample_strobe (sample_strobe),
    .level         (level),
    .ramping       (ramping),
    .pwm_out       (pwm_out),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [6:0] e;
    if (strobe_seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({ramping, level} !== e)
        $display("FAIL level_stream: got ramping=%0b level=%0d, expected ramping=%0b level=%0d",
                 ramping, level, e[6], e[5:0]);
      else
        n_pass++;
    end
    strobe_seen = sample_strobe;
  end

  task automatic wait_drain(input string tag);
    int budget;
    budget = (exp_q.size() + 1) * (DIV + 4);
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_drain: %0d levels pending, expected 0", tag, exp_q.size());
      exp_q.delete();
    end else begin
      n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sample_strobe, level, ramping, pwm_out} !== 9'b0)
      $display("FAIL reset_outputs: got %b, expected 0", {sample_strobe, level, ramping, pwm_out});
    else n_pass++;
    n_checks++;
    if (state_dbg !== OFF) $display("FAIL reset_state: got %0d, expected %0d", state_dbg, OFF);
    else n_pass++;
  endtask

  task automatic test_timebase(input string tag);
    int first_idx, second_idx, n_strobes;
    bit saw_pwm, saw_lvl;
    first_idx = -1; second_idx = -1; n_strobes = 0;
    saw_pwm = 0; saw_lvl = 0;
    enable = 1'b0;
    resetn = 1'b1;
    for (int c = 1; c <= 2 * DIV; c++) begin
      @(negedge clk);
      if (sample_strobe) begin
        n_strobes++;
        if (first_idx < 0) first_idx = c;
        else if (second_idx < 0) second_idx = c;
      end
      if (pwm_out) saw_pwm = 1;
      if (level != 0) saw_lvl = 1;
    end
    n_checks++;
    if (first_idx != DIV) $display("FAIL %s_first_strobe: got clock %0d, expected %0d", tag, first_idx, DIV);
    else n_pass++;
    n_checks++;
    if (second_idx != 2 * DIV) $display("FAIL %s_second_strobe: got clock %0d, expected %0d", tag, second_idx, 2 * DIV);
    else n_pass++;
    n_checks++;
    if (n_strobes != 2) $display("FAIL %s_strobe_count: got %0d, expected 2", tag, n_strobes);
    else n_pass++;
    n_checks++;
    if (saw_pwm) $display("FAIL %s_pwm_idle: got high, expected constant 0", tag);
    else n_pass++;
    n_checks++;
    if (saw_lvl) $display("FAIL %s_level_idle: got nonzero, expected 0", tag);
    else n_pass++;
  endtask

  task automatic test_ramp_up();
    int highs;
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state_dbg !== RAMP_UP || ramping !== 1'b1)
      $display("FAIL ramp_up_enter: got state=%0d ramping=%0b, expected state=%0d ramping=1", state_dbg, ramping, RAMP_UP);
    else n_pass++;
    @(negedge clk);
    for (int v = 1; v <= 32; v++) exp_q.push_back({1'(v != 32), 6'(v)});
    wait_drain("ramp_up");
    n_checks++;
    if (state_dbg !== RUN) $display("FAIL ramp_up_run: got state=%0d, expected %0d", state_dbg, RUN);
    else n_pass++;
    repeat (70) @(negedge clk);
    highs = 0;
    repeat (64) begin @(negedge clk); highs += int'(pwm_out); end
    n_checks++;
    if (highs != 32) $display("FAIL pwm_duty32: got %0d high clocks, expected 32", highs);
    else n_pass++;
  endtask

  task automatic test_run_sample();
    int highs;
    voices_active = 16'h0005;
    sample_in = 6'd50;
    exp_q.push_back({1'b0, 6'd50});
    wait_drain("run_sample");
    repeat (70) @(negedge clk);
    highs = 0;
    repeat (64) begin @(negedge clk); highs += int'(pwm_out); end
    n_checks++;
    if (highs != 50) $display("FAIL pwm_duty50: got %0d high clocks, expected 50", highs);
    else n_pass++;
  endtask

  task automatic test_silent_voices();
    voices_active = 16'h0000;
    sample_in = 6'd63;
    exp_q.push_back({1'b0, 6'd32});
    wait_drain("silent_voices");
    voices_active = 16'h0005;
    sample_in = 6'd50;
    exp_q.push_back({1'b0, 6'd50});
    wait_drain("voices_back");
  endtask

  task automatic test_ramp_down();
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_dbg !== RAMP_DOWN || ramping !== 1'b1)
      $display("FAIL ramp_down_enter: got state=%0d ramping=%0b, expected state=%0d ramping=1", state_dbg, ramping, RAMP_DOWN);
    else n_pass++;
    @(negedge clk);
    for (int v = 49; v >= 0; v--) exp_q.push_back({1'(v != 0), 6'(v)});
    wait_drain("ramp_down_full");
    n_checks++;
    if (state_dbg !== OFF) $display("FAIL ramp_down_off: got state=%0d, expected %0d", state_dbg, OFF);
    else n_pass++;
    enable = 1'b1;
    @(negedge clk);
    for (int v = 1; v <= 32; v++) exp_q.push_back({1'(v != 32), 6'(v)});
    wait_drain("ramp_up_again");
    exp_q.push_back({1'b0, 6'd50});
    wait_drain("run_again");
    enable = 1'b0;
    @(negedge clk);
    for (int v = 49; v >= 20; v--) exp_q.push_back({1'b1, 6'(v)});
    wait_drain("ramp_down_part");
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state_dbg !== RAMP_UP || level !== 6'd20)
      $display("FAIL reraise: got state=%0d level=%0d, expected state=%0d level=20", state_dbg, level, RAMP_UP);
    else n_pass++;
    for (int v = 21; v <= 32; v++) exp_q.push_back({1'(v != 32), 6'(v)});
    wait_drain("ramp_resume");
    n_checks++;
    if (state_dbg !== RUN) $display("FAIL resume_run: got state=%0d, expected %0d", state_dbg, RUN);
    else n_pass++;
  endtask

  task automatic test_reset_mid_ramp();
    int budget;
    enable = 1'b0;
    @(negedge clk);
    for (int v = 31; v >= 29; v--) exp_q.push_back({1'b1, 6'(v)});
    wait_drain("pre_reset_ramp");
    budget = 80;
    while (u_dut.u_dac.pwm_cnt_q != 6'd10 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (pwm_out !== 1'b1 || budget == 0)
      $display("FAIL pre_reset_pwm: got pwm_out=%0b budget=%0d, expected pwm_out=1 at pwm_cnt 10", pwm_out, budget);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({sample_strobe, level, ramping, pwm_out} !== 9'b0)
      $display("FAIL async_reset_outputs: got %b, expected 0", {sample_strobe, level, ramping, pwm_out});
    else n_pass++;
    n_checks++;
    if (state_dbg !== OFF) $display("FAIL async_reset_state: got %0d, expected %0d", state_dbg, OFF);
    else n_pass++;
    repeat (3) @(negedge clk);
    test_timebase("after_reset");
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_timebase("timebase");
    test_ramp_up();
    test_run_sample();
    test_silent_voices();
    test_ramp_down();
    test_reset_mid_ramp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
